// File: rtl/tick_counter_pkg.sv
// Shared definitions for the tick counter core: ALU op codes, counter
// FSM states and button index constants.
`timescale 1ns/1ps
package tick_counter_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_AND = 2'd2,
      OP_XOR = 2'd3
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_RUN_UP   = 2'd0,
      ST_RUN_DOWN = 2'd1,
      ST_PAUSED   = 2'd2
   } cnt_state_e;

   localparam int unsigned BTN_DOWN  = 0;
   localparam int unsigned BTN_PAUSE = 1;
   localparam int unsigned BTN_LOAD  = 2;
   localparam int unsigned BTN_CLEAR = 3;
   localparam int unsigned NUM_BTN   = 4;

   // Run mode selected by the pause/down buttons (pressed = 1).
   function automatic cnt_state_e run_state(input logic pause_p, input logic down_p);
      if (pause_p)
         return ST_PAUSED;
      else if (down_p)
         return ST_RUN_DOWN;
      else
         return ST_RUN_UP;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw active-low button: 2-flop synchroniser followed by a tick-based
// debouncer. The accepted level changes only after DEB_TICKS consecutive
// ticks on which the synchronised level differs from the accepted one.
`timescale 1ns/1ps
module button_debounce
   import tick_counter_pkg::*;
#(
   parameter int unsigned DEB_TICKS = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic button_n,
   input  logic tick,
   output logic accepted
);

   localparam int unsigned CW = $clog2(DEB_TICKS + 1);

   logic [1:0]    sync_q, sync_d;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Synchroniser shift path from the asynchronous pin.
   always_comb begin
      sync_d = {sync_q[0], button_n};
   end

   // Stability counter: any tick agreeing with the accepted level restarts it.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (tick) begin
         if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEB_TICKS - 1)) begin
               level_d = sync_q[1];
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end else begin
            cnt_d = '0;
         end
      end
   end

   // State registers; buttons come out of reset released.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q  <= '1;
         level_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next accepted level, so a command acts on the very tick it is accepted.
   assign accepted = level_d;

endmodule

// File: rtl/tick_counter_core.sv
// Tick-driven up/down counter with debounced button commands, LED mirror
// and a registered host ALU. Single clock domain; no derived clocks.
`timescale 1ns/1ps
module tick_counter_core
   import tick_counter_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 10_000_000,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEB_TICKS = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        button,
   input  logic [DATA_W-1:0] host_a,
   input  logic [DATA_W-1:0] host_b,
   input  logic [1:0]        host_op,
   input  logic [CNT_W-1:0]  host_load,
   output logic [CNT_W-1:0]  led,
   output logic [CNT_W-1:0]  count,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        status
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV);

   logic [DIV_W-1:0]  div_q, div_d;
   logic              tick_q, tick_d;
   logic [3:0]        accepted;
   logic [3:0]        pressed;
   cnt_state_e        state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wrap_q, wrap_d;
   logic              paused_q, paused_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              carry_q, carry_d;
   logic [DATA_W:0]   alu_wide;

   // Divider: counts 0..CLK_DIV-1, strobe registered on the wrap.
   always_comb begin
      tick_d = (div_q == DIV_W'(CLK_DIV - 1));
      div_d  = tick_d ? '0 : div_q + DIV_W'(1);
   end

   // Divider and tick strobe registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      button_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
         .clk      (clk),
         .reset    (reset),
         .button_n (button[i]),
         .tick     (tick_q),
         .accepted (accepted[i])
      );
   end

   assign pressed = ~accepted;

   // Counter FSM next state: command priority clear > load > pause > down > up.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      wrap_d   = wrap_q;
      paused_d = paused_q;
      if (tick_q) begin
         if (pressed[BTN_CLEAR]) begin
            count_d = '0;
            wrap_d  = 1'b0;
            state_d = run_state(pressed[BTN_PAUSE], pressed[BTN_DOWN]);
         end else if (pressed[BTN_LOAD]) begin
            count_d = host_load;
            state_d = run_state(pressed[BTN_PAUSE], pressed[BTN_DOWN]);
         end else if (pressed[BTN_PAUSE]) begin
            state_d = ST_PAUSED;
         end else if (pressed[BTN_DOWN]) begin
            state_d = ST_RUN_DOWN;
            count_d = count_q - CNT_W'(1);
            if (count_q == '0)
               wrap_d = 1'b1;
         end else begin
            state_d = ST_RUN_UP;
            count_d = count_q + CNT_W'(1);
            if (count_q == '1)
               wrap_d = 1'b1;
         end
         paused_d = (state_d == ST_PAUSED);
      end
   end

   // Counter FSM registers with registered paused flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_RUN_UP;
         count_q  <= '0;
         wrap_q   <= 1'b0;
         paused_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         wrap_q   <= wrap_d;
         paused_q <= paused_d;
      end
   end

   // Host ALU: carry is the extra sum bit for add, the borrow for sub.
   always_comb begin
      alu_wide = '0;
      result_d = '0;
      carry_d  = 1'b0;
      case (alu_op_e'(host_op))
         OP_ADD: begin
            alu_wide = {1'b0, host_a} + {1'b0, host_b};
            result_d = alu_wide[DATA_W-1:0];
            carry_d  = alu_wide[DATA_W];
         end
         OP_SUB: begin
            alu_wide = {1'b0, host_a} - {1'b0, host_b};
            result_d = alu_wide[DATA_W-1:0];
            carry_d  = alu_wide[DATA_W];
         end
         OP_AND:  result_d = host_a & host_b;
         default: result_d = host_a ^ host_b;
      endcase
   end

   // ALU result registers, updated every cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         result_q <= '0;
         carry_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         carry_q  <= carry_d;
      end
   end

   assign count  = count_q;
   assign led    = ~count_q;
   assign result = result_q;
   assign status = {wrap_q, carry_q, paused_q, tick_q};

endmodule

// File: tb/tb_tick_counter_core.sv
// Directed bench for tick_counter_core with CLK_DIV=4, CNT_W=4, DEB_TICKS=2.
`timescale 1ns/1ps
module tb_tick_counter_core;

   localparam int unsigned CLK_DIV   = 4;
   localparam int unsigned CNT_W     = 4;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned DEB_TICKS = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [3:0]        button = 4'hF;
   logic [DATA_W-1:0] host_a = '0;
   logic [DATA_W-1:0] host_b = '0;
   logic [1:0]        host_op = 2'd0;
   logic [CNT_W-1:0]  host_load = '0;
   logic [CNT_W-1:0]  led;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] result;
   logic [3:0]        status;

   int total = 0;
   int bad   = 0;
   logic [32:0] sb_q[$];

   tick_counter_core #(
      .CLK_DIV   (CLK_DIV),
      .CNT_W     (CNT_W),
      .DATA_W    (DATA_W),
      .DEB_TICKS (DEB_TICKS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .button    (button),
      .host_a    (host_a),
      .host_b    (host_b),
      .host_op   (host_op),
      .host_load (host_load),
      .led       (led),
      .count     (count),
      .result    (result),
      .status    (status)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for the next tick cycle, then lands just after the edge ending it.
   task automatic wait_tick();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (status[0] === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check("tick_seen", {31'd0, seen}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic counter_step(input string tag, input logic [3:0] exp_cnt,
                               input logic exp_paused, input logic exp_wrap);
      wait_tick();
      check({tag, "_count"}, {28'd0, count}, {28'd0, exp_cnt});
      check({tag, "_led"}, {28'd0, led}, {28'd0, ~exp_cnt});
      check({tag, "_paused"}, {31'd0, status[1]}, {31'd0, exp_paused});
      check({tag, "_wrap"}, {31'd0, status[3]}, {31'd0, exp_wrap});
      check({tag, "_tick_one_cycle"}, {31'd0, status[0]}, 32'd0);
   endtask

   task automatic alu_step(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                           input logic [31:0] exp_r, input logic exp_c);
      logic [32:0] e;
      host_a  = a;
      host_b  = b;
      host_op = op;
      sb_q.push_back({exp_c, exp_r});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("alu_result", result, e[31:0]);
      check("alu_carry", {31'd0, status[2]}, {31'd0, e[32]});
   endtask

   task automatic first_tick_latency();
      int first;
      first = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         if (status[0] === 1'b1) begin
            first = i;
            break;
         end
      end
      check("first_tick_latency", first, CLK_DIV);
   endtask

   initial begin
      logic found;
      // Reset with live ALU operands: outputs must still read reset values.
      reset  = 1'b0;
      host_a = 32'd5;
      host_b = 32'd3;
      repeat (3) @(posedge clk);
      #1;
      check("rst_count", {28'd0, count}, 32'd0);
      check("rst_led", {28'd0, led}, 32'hF);
      check("rst_status", {28'd0, status}, 32'd0);
      check("rst_result", result, 32'd0);

      host_a = '0;
      host_b = '0;
      reset  = 1'b1;
      first_tick_latency();

      // Free-running up count through the wrap.
      for (int k = 1; k <= 16; k++)
         counter_step("up", 4'(k), 1'b0, (k == 16));

      // Clear and load together: clear wins, then load once clear is released.
      host_load = 4'd9;
      button = 4'b0011;
      counter_step("clr_pending", 4'd1, 1'b0, 1'b1);
      counter_step("clr_accept", 4'd0, 1'b0, 1'b0);
      button = 4'b1011;
      counter_step("clr_release_pending", 4'd0, 1'b0, 1'b0);
      counter_step("load_accept", 4'd9, 1'b0, 1'b0);
      button = 4'hF;
      counter_step("load_release_pending", 4'd9, 1'b0, 1'b0);
      counter_step("load_released", 4'd10, 1'b0, 1'b0);

      // Count down through 0 -> 15.
      button = 4'b1110;
      counter_step("down_pending", 4'd11, 1'b0, 1'b0);
      counter_step("down_accept", 4'd10, 1'b0, 1'b0);
      for (int v = 9; v >= 0; v--)
         counter_step("down", 4'(v), 1'b0, 1'b0);
      counter_step("down_wrap", 4'd15, 1'b0, 1'b1);
      button = 4'hF;
      counter_step("down_release_pending", 4'd14, 1'b0, 1'b1);
      counter_step("down_released", 4'd15, 1'b0, 1'b1);

      // Pause glitch for one tick is ignored.
      button = 4'b1101;
      counter_step("glitch", 4'd0, 1'b0, 1'b1);
      button = 4'hF;
      counter_step("glitch_gone", 4'd1, 1'b0, 1'b1);

      // Pause held three ticks, then released.
      button = 4'b1101;
      counter_step("pause_pending", 4'd2, 1'b0, 1'b1);
      counter_step("pause_accept", 4'd2, 1'b1, 1'b1);
      counter_step("pause_hold", 4'd2, 1'b1, 1'b1);
      button = 4'hF;
      counter_step("pause_release_pending", 4'd2, 1'b1, 1'b1);
      counter_step("pause_resumed", 4'd3, 1'b0, 1'b1);

      // ALU: carry/borrow boundaries and logic ops.
      alu_step(32'hFFFF_FFFF, 32'd1, 2'd0, 32'd0, 1'b1);
      alu_step(32'd2, 32'd3, 2'd0, 32'd5, 1'b0);
      alu_step(32'd1, 32'd2, 2'd1, 32'hFFFF_FFFF, 1'b1);
      alu_step(32'd5, 32'd3, 2'd1, 32'd2, 1'b0);
      alu_step(32'h0000_F0F0, 32'h0000_FF00, 2'd3, 32'h0000_0FF0, 1'b0);
      alu_step(32'h0000_F0F0, 32'h0000_FF00, 2'd2, 32'h0000_F000, 1'b0);
      alu_step(32'd0, 32'd0, 2'd0, 32'd0, 1'b0);

      // Reset lands on the tick that would accept a load.
      wait_tick();
      host_load = 4'd9;
      button = 4'b1011;
      wait_tick();
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (status[0] === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      check("load_tick_found", {31'd0, found}, 32'd1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rst2_count", {28'd0, count}, 32'd0);
      check("rst2_led", {28'd0, led}, 32'hF);
      check("rst2_status", {28'd0, status}, 32'd0);
      check("rst2_result", result, 32'd0);
      button = 4'hF;
      @(posedge clk);
      #1;
      reset = 1'b1;
      first_tick_latency();
      counter_step("post_rst", 4'd1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tick_counter_core.md
TICK_COUNTER_CORE -- requirements
Module: tick_counter_core

Interface
REQ-001 Parameter CLK_DIV, default 10_000_000; clk cycles per tick strobe, minimum 2.
REQ-002 Parameter CNT_W, default 8; up/down counter and LED width, 1..32.
REQ-003 Parameter DATA_W, default 32; host operand and result width.
REQ-004 Parameter DEB_TICKS, default 2; consecutive ticks a button level must be stable before it is accepted, minimum 1.
REQ-005 clk  input  1  single system clock, 200 MHz; all logic on posedge clk.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 button  input  4  raw board buttons, asynchronous, active-low (0 = pressed).
REQ-008 host_a, host_b  input  DATA_W each  host wire operands, quasi-static.
REQ-009 host_op  input  2  ALU select: 0 add, 1 sub (a-b), 2 and, 3 xor.
REQ-010 host_load  input  CNT_W  counter preload value.
REQ-011 led  output  CNT_W  bitwise inverse of count (active-low LEDs).
REQ-012 count  output  CNT_W  current counter value.
REQ-013 result  output  DATA_W  registered ALU result.
REQ-014 status  output  4  {wrap_sticky, carry, paused, tick}.

Function
REQ-015 Tick: divider counts 0..CLK_DIV-1 and asserts tick for exactly one clk cycle when it wraps to 0; no derived clock is generated.
REQ-016 Buttons: each bit passes a 2-flop synchroniser, then a per-bit debouncer updating the accepted level only after DEB_TICKS consecutive ticks with an unchanged synchronised level.
REQ-017 Counter FSM states RUN_UP, RUN_DOWN, PAUSED; evaluated only on tick cycles.
REQ-018 Command priority on a tick, highest first: button[3] clears count to 0; button[2] loads host_load; button[1] enters/stays PAUSED; button[0] selects RUN_DOWN; otherwise RUN_UP.
REQ-019 RUN_UP: count+1 per tick; RUN_DOWN: count-1 per tick; PAUSED: count held.
REQ-020 Clear and load take effect on the tick they are accepted, regardless of state, and return to RUN_UP/RUN_DOWN per button[1:0] on that same tick.
REQ-021 Wrap-around: all-ones+1 gives 0 and 0-1 gives all-ones; either sets wrap_sticky, which clears only on clear command or reset.
REQ-022 paused equals 1 exactly while FSM is in PAUSED.
REQ-023 ALU: result and carry register every clk cycle, one-cycle latency from host_a/host_b/host_op.
REQ-024 carry: add = carry-out of DATA_W+1-bit sum; sub = borrow (1 when host_a < host_b, unsigned); and/xor = 0.
REQ-025 Counter changes never occur on non-tick cycles; led always equals ~count in the same cycle.

Reset
REQ-026 While reset=0 at a clk edge: divider=0, tick=0, count=0, led=all-ones, FSM=RUN_UP, debounced levels=1 (released), synchronisers=1, wrap_sticky=0, result=0, carry=0.
REQ-027 Reset asserted mid-operation overrides any pending tick, command or ALU update in that cycle; first tick after release occurs CLK_DIV cycles later.

Structure
REQ-028 Shared package tick_counter_pkg holds ALU op codes, FSM state enum, button index constants.
REQ-029 One sub-module button_debounce (per-bit synchroniser + debouncer, parameter DEB_TICKS), instantiated 4 times.
REQ-030 Host endpoint wiring remains in the board top level; this block has no vendor host primitives.

Verification (CLK_DIV=4, CNT_W=4, DEB_TICKS=2)
REQ-031 Release reset, buttons idle -> tick every 4th cycle; count 0,1,2,... reaching 15 then 0 with wrap_sticky=1; led=~count.
REQ-032 Hold button[0]=0 -> accepted after 2 ticks; count decrements per tick; 0 -> 15 sets wrap_sticky.
REQ-033 Glitch button[1] low for 1 tick -> ignored; hold 3 ticks -> paused=1, count frozen; release -> resumes after 2 ticks.
REQ-034 host_load=9, press button[2] and button[3] together -> count=0 (clear wins), wrap_sticky=0; release button[3] only -> count=9 on accepting tick.
REQ-035 host_a=0xFFFFFFFF, host_b=1, op add -> next cycle result=0, carry=1; op sub with a=1,b=2 -> result=0xFFFFFFFF, carry=1; op xor a=0xF0F0,b=0xFF00 -> 0x0FF0, carry=0.
REQ-036 Assert reset on the cycle a tick and load would coincide -> count=0, all outputs per REQ-026, no load applied.
